// File: rtl/iic_wrbyte.sv
// iic_wrbyte: I2C master byte transmitter. Shifts one byte out MSB-first, releases SDA for the 9th clock and samples the slave ACK.
// Optional arbitration-loss detection is enabled by defining IIC_WRBYTE_ARB_EN.
module iic_wrbyte (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       start,
   input  logic [7:0] tx_byte,
   input  logic       scl_lc,
   input  logic       scl_hc,
   input  logic       scl_ls,
   input  logic       sda_in,
   output logic       sdaw,
   output logic       sdalink,
   output logic       busy,
   output logic       done,
   output logic       ack_ok,
   output logic       nack,
   output logic       arb_lost
);

   typedef enum logic [1:0] {IDLE, DATA, ACK, HOLD} state_t;

   state_t     state, state_nxt;
   logic [7:0] shreg, shreg_nxt;
   logic [2:0] bit_cnt, bit_cnt_nxt;
   logic       drv, drv_nxt;
   logic       sdaw_nxt, sdalink_nxt, busy_nxt, done_nxt, ack_ok_nxt, nack_nxt;
   logic       lc, hc, ls;

   // The sample strobe wins if the strobe source ever overlaps phases.
   assign hc = scl_hc;
   assign lc = scl_lc & ~scl_hc;
   assign ls = scl_ls & ~scl_hc;

`ifdef IIC_WRBYTE_ARB_EN
   logic arb_lost_nxt;
   logic arb_hit;

   // We released-high but the bus reads low: another master owns the line.
   assign arb_hit = sdaw & ~sda_in;
`else
   assign arb_lost = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (clr) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: if (start) state_nxt = DATA;
            DATA: begin
               if (hc && drv) begin
`ifdef IIC_WRBYTE_ARB_EN
                  if (arb_hit)                state_nxt = IDLE;
                  else if (bit_cnt == 3'd0)   state_nxt = ACK;
`else
                  if (bit_cnt == 3'd0)        state_nxt = ACK;
`endif
               end
            end
            ACK:  if (hc && drv) state_nxt = HOLD;
            HOLD: if (ls) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      // NOTE: every *_nxt is given its hold value first so no branch can infer a latch.
      shreg_nxt   = shreg;
      bit_cnt_nxt = bit_cnt;
      drv_nxt     = drv;
      sdaw_nxt    = sdaw;
      sdalink_nxt = sdalink;
      busy_nxt    = busy;
      done_nxt    = 1'b0;
      ack_ok_nxt  = ack_ok;
      nack_nxt    = nack;
`ifdef IIC_WRBYTE_ARB_EN
      arb_lost_nxt = arb_lost;
`endif
      if (clr) begin
         sdalink_nxt = 1'b0;
         sdaw_nxt    = 1'b1;
         busy_nxt    = 1'b0;
         drv_nxt     = 1'b0;
         bit_cnt_nxt = 3'd7;
         ack_ok_nxt  = 1'b0;
         nack_nxt    = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  shreg_nxt   = tx_byte;
                  bit_cnt_nxt = 3'd7;
                  busy_nxt    = 1'b1;
                  drv_nxt     = 1'b0;
                  ack_ok_nxt  = 1'b0;
                  nack_nxt    = 1'b0;
`ifdef IIC_WRBYTE_ARB_EN
                  arb_lost_nxt = 1'b0;
`endif
               end
            end
            DATA: begin
               if (lc) begin
                  sdalink_nxt = 1'b1;
                  sdaw_nxt    = shreg[bit_cnt];
                  drv_nxt     = 1'b1;
               end else if (hc && drv) begin
                  // Only an hc that follows our own lc counts as a bit.
                  drv_nxt = 1'b0;
`ifdef IIC_WRBYTE_ARB_EN
                  if (arb_hit) begin
                     arb_lost_nxt = 1'b1;
                     sdalink_nxt  = 1'b0;
                     sdaw_nxt     = 1'b1;
                     done_nxt     = 1'b1;
                     busy_nxt     = 1'b0;
                     ack_ok_nxt   = 1'b0;
                     nack_nxt     = 1'b0;
                     bit_cnt_nxt  = 3'd7;
                  end else if (bit_cnt != 3'd0) begin
                     bit_cnt_nxt = bit_cnt - 3'd1;
                  end
`else
                  if (bit_cnt != 3'd0) bit_cnt_nxt = bit_cnt - 3'd1;
`endif
               end
            end
            ACK: begin
               if (lc) begin
                  sdalink_nxt = 1'b0;
                  sdaw_nxt    = 1'b1;
                  drv_nxt     = 1'b1;
               end else if (hc && drv) begin
                  drv_nxt    = 1'b0;
                  ack_ok_nxt = ~sda_in;
                  nack_nxt   = sda_in;
               end
            end
            HOLD: begin
               if (ls) begin
                  done_nxt = 1'b1;
                  busy_nxt = 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg   <= 8'h00;
         bit_cnt <= 3'd7;
         drv     <= 1'b0;
         sdaw    <= 1'b1;
         sdalink <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         ack_ok  <= 1'b0;
         nack    <= 1'b0;
      end else begin
         shreg   <= shreg_nxt;
         bit_cnt <= bit_cnt_nxt;
         drv     <= drv_nxt;
         sdaw    <= sdaw_nxt;
         sdalink <= sdalink_nxt;
         busy    <= busy_nxt;
         done    <= done_nxt;
         ack_ok  <= ack_ok_nxt;
         nack    <= nack_nxt;
      end
   end

`ifdef IIC_WRBYTE_ARB_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) arb_lost <= 1'b0;
      else        arb_lost <= arb_lost_nxt;
   end
`endif

endmodule

// File: tb/tb_iic_wrbyte.sv
// tb_iic_wrbyte: self-checking bench for iic_wrbyte; byte-level model (bits seen on the bus, ACK slot, single done pulse).
module tb_iic_wrbyte;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clr = 1'b0;
   logic       start = 1'b0;
   logic [7:0] tx_byte = 8'h00;
   logic       scl_lc = 1'b0, scl_hc = 1'b0, scl_ls = 1'b0;
   logic       sda_in = 1'b1;
   logic       sdaw, sdalink, busy, done, ack_ok, nack, arb_lost;

   int n_cmp = 0;
   int n_err = 0;
   int done_cnt = 0;

   iic_wrbyte dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .start(start), .tx_byte(tx_byte),
      .scl_lc(scl_lc), .scl_hc(scl_hc), .scl_ls(scl_ls), .sda_in(sda_in),
      .sdaw(sdaw), .sdalink(sdalink), .busy(busy), .done(done),
      .ack_ok(ack_ok), .nack(nack), .arb_lost(arb_lost)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (done === 1'b1) done_cnt++;

   typedef struct {
      logic [7:0] tx;
      logic       slave_ack;
      logic       exp_ack_ok;
      logic       exp_nack;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic pulse_lc();
      scl_lc = 1'b1; tick(); scl_lc = 1'b0;
   endtask

   task automatic pulse_hc();
      scl_hc = 1'b1; tick(); scl_hc = 1'b0;
   endtask

   task automatic pulse_ls();
      scl_ls = 1'b1; tick(); scl_ls = 1'b0;
   endtask

   // One SCL clock: low-centre, then high-centre sample. The bus is a wired-AND of master and slave.
   task automatic scl_clock(input logic slave_low, output logic bus, output logic link);
      idle(int'($urandom_range(0, 2)));
      pulse_lc();
      idle(int'($urandom_range(0, 2)));
      link   = sdalink;
      bus    = ~((sdalink & ~sdaw) | slave_low);
      sda_in = bus;
      pulse_hc();
      sda_in = 1'b1;
   endtask

   task automatic run_byte(input logic [7:0] tx, input logic slave_ack, input logic exp_ack_ok,
                           input logic exp_nack, input int inject_at, input logic early_hc,
                           input string tag);
      logic [7:0] seen;
      logic [8:0] links;
      logic       bus, link;
      int         d0;
      seen  = 8'h00;
      links = 9'h000;
      d0    = done_cnt;
      start = 1'b1; tx_byte = tx; tick(); start = 1'b0; tx_byte = 8'($urandom);
      check({tag, " busy after start"}, busy, 1);
      check({tag, " flags cleared"}, {ack_ok, nack, arb_lost}, 0);
      if (early_hc) begin
         idle(1);
         pulse_hc();
      end
      for (int i = 0; i < 8; i++) begin
         if (i == inject_at) begin
            start = 1'b1; tx_byte = 8'hFF; tick(); start = 1'b0;
         end
         scl_clock(1'b0, bus, link);
         seen[7-i]  = bus;
         links[8-i] = link;
         pulse_ls();
      end
      scl_clock(slave_ack, bus, link);
      links[0] = link;
      check({tag, " bits on bus"}, seen, tx);
      check({tag, " sda enable per clock"}, links, 9'h1FE);
      check({tag, " ack_ok"}, ack_ok, exp_ack_ok);
      check({tag, " nack"}, nack, exp_nack);
      idle(int'($urandom_range(0, 2)));
      check({tag, " busy before ls"}, busy, 1);
      check({tag, " no early done"}, done_cnt - d0, 0);
      pulse_ls();
      check({tag, " done pulse"}, done, 1);
      check({tag, " busy drops with done"}, busy, 0);
      tick();
      check({tag, " done one cycle"}, done, 0);
      check({tag, " done count"}, done_cnt - d0, 1);
      check({tag, " ack_ok held"}, {ack_ok, nack}, {exp_ack_ok, exp_nack});
      check({tag, " no arb_lost"}, arb_lost, 0);
      check({tag, " sda released"}, sdalink, 0);
   endtask

   logic bus_v, link_v;
   int   d0_v;

   initial begin
      vecs[0] = '{tx: 8'hA5, slave_ack: 1'b1, exp_ack_ok: 1'b1, exp_nack: 1'b0};
      vecs[1] = '{tx: 8'h80, slave_ack: 1'b0, exp_ack_ok: 1'b0, exp_nack: 1'b1};
      vecs[2] = '{tx: 8'h00, slave_ack: 1'b1, exp_ack_ok: 1'b1, exp_nack: 1'b0};
      vecs[3] = '{tx: 8'hFF, slave_ack: 1'b0, exp_ack_ok: 1'b0, exp_nack: 1'b1};
      vecs[4] = '{tx: 8'h69, slave_ack: 1'b0, exp_ack_ok: 1'b0, exp_nack: 1'b1};
      vecs[5] = '{tx: 8'h3C, slave_ack: 1'b1, exp_ack_ok: 1'b1, exp_nack: 1'b0};

      idle(2);
      check("reset outputs", {sdaw, sdalink, busy, done, ack_ok, nack, arb_lost}, 7'b1000000);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 6; i++)
         run_byte(vecs[i].tx, vecs[i].slave_ack, vecs[i].exp_ack_ok, vecs[i].exp_nack, -1, 1'b0,
                  $sformatf("vec%0d", i));

      // Start while busy: a second request at bit 3 must not disturb a 0x00 transfer.
      run_byte(8'h00, 1'b1, 1'b1, 1'b0, 4, 1'b0, "start while busy");

      // clr in IDLE wipes the held ACK result.
      clr = 1'b1; tick(); clr = 1'b0;
      check("clr clears ack_ok", {ack_ok, nack}, 2'b00);

      // Abort after the 4th sampled bit.
      d0_v  = done_cnt;
      start = 1'b1; tx_byte = 8'h5A; tick(); start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         scl_clock(1'b0, bus_v, link_v);
         pulse_ls();
      end
      idle(1);
      pulse_lc();
      check("abort pre driving", sdalink, 1);
      clr = 1'b1; tick(); clr = 1'b0;
      check("abort released", {sdalink, sdaw, busy, done}, 4'b0100);
      pulse_hc();
      pulse_ls();
      idle(3);
      check("abort no done", done_cnt - d0_v, 0);
      check("abort stays idle", {busy, sdalink}, 2'b00);
      run_byte(8'h3C, 1'b1, 1'b1, 1'b0, -1, 1'b0, "after abort");

      // clr and start together: clr wins.
      clr = 1'b1; start = 1'b1; tx_byte = 8'h00; tick(); clr = 1'b0; start = 1'b0;
      check("clr beats start busy", busy, 0);
      pulse_lc();
      check("clr beats start no drive", sdalink, 0);

      // Asynchronous reset while in the ACK slot.
      start = 1'b1; tx_byte = 8'hC3; tick(); start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         scl_clock(1'b0, bus_v, link_v);
         pulse_ls();
      end
      idle(1);
      pulse_lc();
      check("pre-reset busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check("async reset outputs", {sdaw, sdalink, busy, done, ack_ok, nack, arb_lost}, 7'b1000000);
      tick();
      rst_n = 1'b1;
      tick();
      run_byte(8'h96, 1'b0, 1'b0, 1'b1, -1, 1'b1, "after reset");

      // Randomised bytes against the byte-level model.
      for (int i = 0; i < 16; i++) begin
         logic [7:0] t;
         logic       a;
         t = 8'($urandom);
         a = 1'($urandom);
         run_byte(t, a, a, ~a, -1, 1'($urandom), $sformatf("rand%0d", i));
      end

`ifdef IIC_WRBYTE_ARB_EN
      // Another master pulls SDA low while we send bit 6 (a 1) of 0xF0.
      d0_v  = done_cnt;
      start = 1'b1; tx_byte = 8'hF0; tick(); start = 1'b0;
      scl_clock(1'b0, bus_v, link_v);
      pulse_ls();
      scl_clock(1'b1, bus_v, link_v);
      check("arb lost flag", arb_lost, 1);
      check("arb releases sda", sdalink, 0);
      check("arb done pulse", {done, busy}, 2'b10);
      check("arb no ack result", {ack_ok, nack}, 2'b00);
      tick();
      check("arb done one cycle", done_cnt - d0_v, 1);
      for (int i = 0; i < 3; i++) begin
         pulse_lc();
         idle(1);
         check("arb no further drive", sdalink, 0);
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/iic_wrbyte.md
# iic_wrbyte

Master-side I2C byte transmitter with slave-acknowledge check. It is the counterpart to the read-side ACK generator: the read path has the master drive ACK after receiving a byte, while this block shifts one byte out MSB-first on SDA, releases the line for the 9th clock, and samples the slave's ACK/NACK. It sits under the I2C master sequencer, sharing the SCL phase strobes and the SDA tristate mux (`sdalink` = output enable) with the other `iic_*` sub-blocks.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  system clock (100 MHz)
- `rst_n`  in  1  reset; asynchronous, active-low
- `clr`  in  1  synchronous abort; returns to IDLE and releases SDA
- `start`  in  1  one-cycle request; accepted only in IDLE
- `tx_byte`  in  8  byte to send; sampled on the accepted `start`
- `scl_lc`  in  1  one-cycle strobe at the SCL-low centre (data change point)
- `scl_hc`  in  1  one-cycle strobe at the SCL-high centre (sample point)
- `scl_ls`  in  1  one-cycle strobe at the SCL falling edge (start of low phase)
- `sda_in`  in  1  synchronised SDA pad input
- `sdaw`  out  1  SDA output value
- `sdalink`  out  1  SDA output enable; 1 drives `sdaw`, 0 releases the line
- `busy`  out  1  high from the accepted `start` until `done`
- `done`  out  1  one-cycle completion pulse
- `ack_ok`  out  1  slave ACKed (SDA low at the 9th `scl_hc`); held until the next `start`
- `nack`  out  1  slave NACKed; held until the next `start`
- `arb_lost`  out  1  arbitration lost; held until the next `start`; constant 0 unless the macro is defined

## Operation
- Reset values: `sdaw`=1, `sdalink`=0, `busy`=0, `done`=0, `ack_ok`=0, `nack`=0, `arb_lost`=0; state IDLE; `bit_cnt`=7.
- The strobe source guarantees that `scl_lc`, `scl_hc` and `scl_ls` are mutually exclusive. If two are asserted in the same cycle, `scl_hc` takes priority.
- States:
  - **IDLE**
    - On `start`: load the shift register from `tx_byte`, `bit_cnt`=7, `busy`=1, clear `ack_ok`/`nack`/`arb_lost`, go to DATA.
    - SCL is low when `start` arrives.
  - **DATA**
    - On `scl_lc`: `sdalink`=1, `sdaw`=`shreg[bit_cnt]`, set the `drv` flag.
    - On `scl_hc` with `drv`=1: clear `drv`. If `bit_cnt`==0 go to ACK, else `bit_cnt`--.
    - `scl_hc` without a preceding `scl_lc` is ignored, so the first clock is never counted early.
  - **ACK**
    - On `scl_lc`: `sdalink`=0, `sdaw`=1, set `drv`.
    - On `scl_hc` with `drv`: `ack_ok`=~`sda_in`, `nack`=`sda_in`, go to HOLD.
  - **HOLD**
    - On `scl_ls`: `done`=1 for one cycle, `busy`=0, go to IDLE. SDA stays released.
- `start` while `busy`=1 is ignored. `tx_byte` changes after acceptance have no effect.
- `clr` in any state:
  - next cycle: IDLE, `sdalink`=0, `sdaw`=1, `busy`=0;
  - no `done` pulse;
  - `ack_ok`/`nack` cleared.
- `clr` and `start` in the same cycle: `clr` wins and `start` is dropped.
- Asynchronous reset mid-byte: all outputs return to reset values immediately and SDA is released.

## Timing
- Register outputs only; there are no combinational paths from inputs to outputs.
- `sdaw`/`sdalink` update 1 clk after the `scl_lc` strobe.
- `ack_ok`/`nack` are valid 1 clk after the 9th `scl_hc` and remain stable through `done`.
- `done` asserts 1 clk after the `scl_ls` that follows the ACK sample.
- One byte takes exactly 9 SCL periods, plus up to one SCL low phase before the first `scl_lc`.

## Configuration
- Macro: `IIC_WRBYTE_ARB_EN`.
- **Defined:**
  - In DATA, on a counted `scl_hc`, if `sdaw`=1 and `sda_in`=0:
    - `arb_lost`=1 and `sdalink`=0 in the next cycle;
    - go directly to IDLE with a `done` pulse;
    - `ack_ok`=`nack`=0.
  - No check is made in ACK.
- **Undefined:**
  - No arbitration check.
  - `arb_lost` is tied to 0.

## Test plan
- **ACK case:** `start`, `tx_byte`=0xA5, slave pulls SDA low at the 9th `scl_hc` -> SDA sequence 1,0,1,0,0,1,0,1 at `scl_hc`; `sdalink`=0 during the 9th clock; `ack_ok`=1, `nack`=0; one `done` after the next `scl_ls`.
- **NACK case:** `tx_byte`=0x80, SDA left high in the ACK slot -> `nack`=1, `ack_ok`=0, `done` pulses once, `busy` falls with `done`.
- **Start while busy:** `start` with `tx_byte`=0xFF at bit 3 of a 0x00 transfer -> ignored; all 8 bits transmitted are 0.
- **Abort:** `clr` after the 4th `scl_hc` -> `sdalink`=0 and `busy`=0 next cycle; no `done`; a subsequent `start` with 0x3C transmits correctly.
- **Reset mid-operation:** `rst_n` low during ACK -> all outputs at reset values immediately; `ack_ok`=`nack`=0.
- **Arbitration (`IIC_WRBYTE_ARB_EN`):** `tx_byte`=0xF0, SDA forced low at bit 6 -> `arb_lost`=1, `sdalink`=0 at the next clk, `done` pulses, no further bits driven.
